// File: rtl/noc_router.sv
// Five-port XY mesh router: per-input FIFOs, per-output round-robin allocation,
// single-flit packets with destination coordinates in the low bits.
module noc_router #(
  parameter int LOC_X     = 0,
  parameter int LOC_Y     = 0,
  parameter int NOC_SIZE  = 4,
  parameter int BUS_WIDTH = 32,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] north_in,
  input  logic [BUS_WIDTH-1:0] south_in,
  input  logic [BUS_WIDTH-1:0] east_in,
  input  logic [BUS_WIDTH-1:0] west_in,
  input  logic [BUS_WIDTH-1:0] local_in,
  input  logic                 bf_inp_north,
  input  logic                 bf_inp_south,
  input  logic                 bf_inp_east,
  input  logic                 bf_inp_west,
  input  logic                 bf_inp_local,
  output logic                 bf_op_north,
  output logic                 bf_op_south,
  output logic                 bf_op_east,
  output logic                 bf_op_west,
  output logic                 bf_op_local,
  output logic [BUS_WIDTH-1:0] north_out,
  output logic [BUS_WIDTH-1:0] south_out,
  output logic [BUS_WIDTH-1:0] east_out,
  output logic [BUS_WIDTH-1:0] west_out,
  output logic [BUS_WIDTH-1:0] local_out
);
  localparam int CW   = (NOC_SIZE > 2) ? $clog2(NOC_SIZE) : 1;
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [CW-1:0]   LX   = CW'(LOC_X);
  localparam logic [CW-1:0]   LY   = CW'(LOC_Y);
  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

  typedef logic [BUS_WIDTH-1:0] flit_t;

  flit_t       in_s [5];
  logic [4:0]  bf_inp_s;
  flit_t       mem_q [5][DEPTH];
  flit_t       mem_d [5][DEPTH];
  logic [AW-1:0]   wr_q [5], wr_d [5], rd_q [5], rd_d [5];
  logic [CNTW-1:0] cnt_q [5], cnt_d [5];
  logic [4:0]  full_q, full_d;
  flit_t       out_q [5], out_d [5];
  logic [2:0]  ptr_q [5], ptr_d [5];
  flit_t       head_s [5];
  logic [2:0]  route_s [5];
  logic [4:0]  req_s [5];
  logic [3:0]  pick_s [5];
  logic [4:0]  push_s, pop_s;

  assign in_s[0] = north_in;
  assign in_s[1] = south_in;
  assign in_s[2] = east_in;
  assign in_s[3] = west_in;
  assign in_s[4] = local_in;
  assign bf_inp_s = {bf_inp_local, bf_inp_west, bf_inp_east, bf_inp_south, bf_inp_north};

  // Output index order: north 0, south 1, east 2, west 3, local 4.
  function automatic logic [2:0] xy_route(input logic [2*CW-1:0] coord);
    logic [CW-1:0] dx, dy;
    dx = coord[2*CW-1:CW];
    dy = coord[CW-1:0];
    if (dx > LX)      return 3'd2;
    else if (dx < LX) return 3'd3;
    else if (dy > LY) return 3'd0;
    else if (dy < LY) return 3'd1;
    else              return 3'd4;
  endfunction

  // Returns {valid, index} of the first requester at or after ptr, wrapping 4 -> 0.
  function automatic logic [3:0] rr_pick(input logic [4:0] req, input logic [2:0] ptr);
    logic [3:0] res;
    logic [3:0] sum;
    res = 4'd0;
    for (int k = 4; k >= 0; k--) begin
      sum = {1'b0, ptr} + 4'(k);
      sum = (sum >= 4'd5) ? (sum - 4'd5) : sum;
      res = req[sum[2:0]] ? {1'b1, sum[2:0]} : res;
    end
    return res;
  endfunction

  // Head routing and per-output allocation.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      head_s[i]  = mem_q[i][rd_q[i]];
      route_s[i] = xy_route(head_s[i][2*CW-1:0]);
    end
    for (int o = 0; o < 5; o++) begin
      for (int i = 0; i < 5; i++) begin
        req_s[o][i] = (cnt_q[i] != '0) && (route_s[i] == 3'(o));
      end
      pick_s[o] = bf_inp_s[o] ? 4'd0 : rr_pick(req_s[o], ptr_q[o]);
    end
  end

  // Next-state for FIFOs, outputs and round-robin pointers.
  always_comb begin
    pop_s = 5'd0;
    for (int o = 0; o < 5; o++) begin
      for (int i = 0; i < 5; i++) begin
        pop_s[i] = pop_s[i] | (pick_s[o][3] && (pick_s[o][2:0] == 3'(i)));
      end
    end
    mem_d = mem_q;
    for (int i = 0; i < 5; i++) begin
      push_s[i] = in_s[i][BUS_WIDTH-1] && (cnt_q[i] != FULL);
      wr_d[i]   = push_s[i] ? wr_q[i] + AW'(1) : wr_q[i];
      rd_d[i]   = pop_s[i] ? rd_q[i] + AW'(1) : rd_q[i];
      if (push_s[i]) begin
        mem_d[i][wr_q[i]] = in_s[i];
      end else begin
        mem_d[i][wr_q[i]] = mem_q[i][wr_q[i]];
      end
      case ({push_s[i], pop_s[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNTW'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNTW'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
      full_d[i] = (cnt_d[i] == FULL);
    end
    for (int o = 0; o < 5; o++) begin
      out_d[o] = pick_s[o][3] ? head_s[pick_s[o][2:0]] : '0;
      ptr_d[o] = !pick_s[o][3] ? ptr_q[o] :
                 (pick_s[o][2:0] == 3'd4) ? 3'd0 : pick_s[o][2:0] + 3'd1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 5; i++) begin
        for (int d = 0; d < DEPTH; d++) begin
          mem_q[i][d] <= '0;
        end
        wr_q[i]  <= '0;
        rd_q[i]  <= '0;
        cnt_q[i] <= '0;
        out_q[i] <= '0;
        ptr_q[i] <= 3'd0;
      end
      full_q <= 5'd0;
    end else begin
      mem_q  <= mem_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      ptr_q  <= ptr_d;
      full_q <= full_d;
    end
  end

  assign north_out   = out_q[0];
  assign south_out   = out_q[1];
  assign east_out    = out_q[2];
  assign west_out    = out_q[3];
  assign local_out   = out_q[4];
  assign bf_op_north = full_q[0];
  assign bf_op_south = full_q[1];
  assign bf_op_east  = full_q[2];
  assign bf_op_west  = full_q[3];
  assign bf_op_local = full_q[4];
endmodule

// File: tb/tb_noc_router.sv
// Bench for noc_router at node (1,2) of a 4x4 mesh: directed routing, arbitration,
// backpressure and reset steps, then random traffic against per-port queues.
module tb_noc_router;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_v [5];
  logic [4:0]  bf_v = 5'd0;
  logic [31:0] outs [5];
  logic [4:0]  bfo;
  logic [31:0] north_in, south_in, east_in, west_in, local_in;
  logic [31:0] north_out, south_out, east_out, west_out, local_out;
  logic        bf_op_north, bf_op_south, bf_op_east, bf_op_west, bf_op_local;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q [25][$];

  always #5 clk = ~clk;

  assign north_in = in_v[0];
  assign south_in = in_v[1];
  assign east_in  = in_v[2];
  assign west_in  = in_v[3];
  assign local_in = in_v[4];
  assign outs[0] = north_out;
  assign outs[1] = south_out;
  assign outs[2] = east_out;
  assign outs[3] = west_out;
  assign outs[4] = local_out;
  assign bfo = {bf_op_local, bf_op_west, bf_op_east, bf_op_south, bf_op_north};

  noc_router #(.LOC_X(1), .LOC_Y(2), .NOC_SIZE(4), .BUS_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .north_in(north_in), .south_in(south_in), .east_in(east_in),
    .west_in(west_in), .local_in(local_in),
    .bf_inp_north(bf_v[0]), .bf_inp_south(bf_v[1]), .bf_inp_east(bf_v[2]),
    .bf_inp_west(bf_v[3]), .bf_inp_local(bf_v[4]),
    .bf_op_north(bf_op_north), .bf_op_south(bf_op_south), .bf_op_east(bf_op_east),
    .bf_op_west(bf_op_west), .bf_op_local(bf_op_local),
    .north_out(north_out), .south_out(south_out), .east_out(east_out),
    .west_out(west_out), .local_out(local_out)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [159:0] all_outs();
    return {outs[4], outs[3], outs[2], outs[1], outs[0]};
  endfunction

  function automatic logic [159:0] one_out(input int p, input logic [31:0] f);
    logic [159:0] r;
    r = '0;
    r[p*32 +: 32] = f;
    return r;
  endfunction

  // XY rule for node (1,2): x first, then y, else local.
  function automatic int exp_port(input logic [31:0] f);
    int dx, dy;
    dx = int'(f[3:2]);
    dy = int'(f[1:0]);
    if (dx > 1) return 2;
    if (dx < 1) return 3;
    if (dy > 2) return 0;
    if (dy < 2) return 1;
    return 4;
  endfunction

  function automatic logic [31:0] mk(input int src, input int seq, input int dx, input int dy);
    return {1'b1, 3'(src), 24'(seq), 2'(dx), 2'(dy)};
  endfunction

  initial begin
    logic [31:0] t1_f [6];
    int          t1_p [6];
    logic [31:0] f, expf;
    int          pushes, seq, src, o;
    logic [4:0]  bf_prev;

    for (int i = 0; i < 5; i++) in_v[i] = 32'd0;
    #3;
    chk("reset_outs", all_outs(), 160'd0);
    chk("reset_bfop", {155'd0, bfo}, 160'd0);
    #9 rst = 1'b1;

    // Routing and 2-edge latency from the local port.
    t1_f = '{32'h8000000E, 32'h80000006, 32'h80000004, 32'h80000003, 32'h8000000B, 32'h80000007};
    t1_p = '{2, 4, 1, 3, 2, 0};
    for (int k = 0; k < 6; k++) begin
      step();
      in_v[4] = t1_f[k];
      step();
      in_v[4] = 32'd0;
      chk("lat_edge1", all_outs(), 160'd0);
      step();
      chk("route", all_outs(), one_out(t1_p[k], t1_f[k]));
      step();
      chk("one_cycle", all_outs(), 160'd0);
    end

    // Four-way contention for east, then a round proving the pointer moved.
    in_v[0] = 32'h8000100E;
    in_v[1] = 32'h8000200E;
    in_v[3] = 32'h8000400E;
    in_v[4] = 32'h8000500E;
    step();
    for (int i = 0; i < 5; i++) in_v[i] = 32'd0;
    chk("rr_push", all_outs(), 160'd0);
    step(); chk("rr_n", all_outs(), one_out(2, 32'h8000100E));
    step(); chk("rr_s", all_outs(), one_out(2, 32'h8000200E));
    step(); chk("rr_w", all_outs(), one_out(2, 32'h8000400E));
    step(); chk("rr_l", all_outs(), one_out(2, 32'h8000500E));
    in_v[1] = 32'h8000600E;
    step();
    in_v[1] = 32'd0;
    step(); chk("rr2_s", all_outs(), one_out(2, 32'h8000600E));
    in_v[0] = 32'h8000700E;
    in_v[4] = 32'h8000800E;
    step();
    in_v[0] = 32'd0;
    in_v[4] = 32'd0;
    step(); chk("rr2_l_first", all_outs(), one_out(2, 32'h8000800E));
    step(); chk("rr2_n_next", all_outs(), one_out(2, 32'h8000700E));

    // Backpressure on east while west streams until its FIFO is full.
    bf_v[2] = 1'b1;
    pushes = 0;
    for (int k = 0; k < 8; k++) begin
      if (bf_op_west) break;
      in_v[3] = 32'h80000E0E + 32'(k << 8);
      step();
      pushes++;
      chk("bp_hold", {128'd0, east_out}, 160'd0);
    end
    in_v[3] = 32'd0;
    chk("bp_pushes", 160'(pushes), 160'd4);
    chk("bp_full", {159'd0, bf_op_west}, 160'd1);
    bf_v[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("bp_drain", all_outs(), one_out(2, 32'h80000E0E + 32'(k << 8)));
      if (k == 0) chk("bp_fall", {159'd0, bf_op_west}, 160'd0);
    end
    step();
    chk("bp_done", all_outs(), 160'd0);

    // Idle flits are ignored.
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 5; i++) in_v[i] = {1'b0, 31'($urandom)};
      step();
      chk("idle", {all_outs(), bfo}, 165'd0);
    end
    for (int i = 0; i < 5; i++) in_v[i] = 32'd0;

    // Asynchronous reset with buffered flits.
    bf_v = 5'b11111;
    for (int k = 0; k < 4; k++) begin
      in_v[0] = 32'h8000900E + 32'(k << 4);
      in_v[4] = (k == 0) ? 32'h8000A00E : 32'd0;
      step();
    end
    in_v[0] = 32'd0;
    in_v[4] = 32'd0;
    chk("rst_pre_full", {159'd0, bf_op_north}, 160'd1);
    bf_v[2] = 1'b0;
    step();
    chk("rst_pre_valid", {159'd0, east_out[31]}, 160'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_async", {all_outs(), bfo}, 165'd0);
    #4 rst = 1'b1;
    bf_v = 5'd0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rst_no_stale", {all_outs(), bfo}, 165'd0);
    end

    // Random traffic honouring bf_op, with random downstream backpressure.
    seq = 0;
    bf_prev = 5'd0;
    for (int cyc = 0; cyc < 1040; cyc++) begin
      step();
      for (int p = 0; p < 5; p++) begin
        chk("rnd_bp", {159'd0, outs[p][31] & bf_prev[p]}, 160'd0);
        if (outs[p][31]) begin
          src = int'(outs[p][30:28]);
          if (src <= 4 && exp_q[p*5+src].size() > 0) expf = exp_q[p*5+src].pop_front();
          else expf = ~outs[p];
          chk("rnd_flit", {128'd0, outs[p]}, {128'd0, expf});
        end
      end
      bf_prev = 5'd0;
      for (int p = 0; p < 5; p++) bf_prev[p] = (cyc < 1000) && ($urandom_range(3, 0) == 0);
      bf_v = bf_prev;
      for (int i = 0; i < 5; i++) begin
        if (cyc < 1000 && !bfo[i] && $urandom_range(1, 0) == 1) begin
          f = mk(i, seq, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
          seq++;
          in_v[i] = f;
          o = exp_port(f);
          exp_q[o*5+i].push_back(f);
        end else begin
          in_v[i] = {1'b0, 31'($urandom)};
        end
      end
    end
    for (int q = 0; q < 25; q++) chk("rnd_left", 160'(exp_q[q].size()), 160'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/noc_router.md
Name: noc_router

Overview:
- Five-port (north, south, east, west, local) input-buffered wormhole-less mesh router for an NOC_SIZE x NOC_SIZE network-on-chip; one instance per mesh node, with the local port attached to the node's processing element.
- Each 32-bit flit is a self-contained packet carrying its destination coordinates.
- Each flit is routed with deterministic XY (dimension-ordered) routing.
- Each output is arbitrated round-robin.
- Per-port full flags (bf_*) provide backpressure in both directions.

Parameters:
- LOC_X, 0, X coordinate of this router (0..NOC_SIZE-1).
- LOC_Y, 0, Y coordinate of this router (0..NOC_SIZE-1).
- NOC_SIZE, 4, mesh dimension. CW = $clog2(NOC_SIZE) is the coordinate field width (minimum 1).
- BUS_WIDTH, 32, flit width.
- DEPTH, 4, input FIFO depth per port (power of two).

Ports:
- clk, input, 1, single system clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-low reset.
- north_in / south_in / east_in / west_in / local_in, input, BUS_WIDTH, incoming flit per port.
- bf_inp_north / bf_inp_south / bf_inp_east / bf_inp_west / bf_inp_local, input, 1, downstream buffer-full for the corresponding output; 1 = do not send.
- bf_op_north / bf_op_south / bf_op_east / bf_op_west / bf_op_local, output, 1, this router's input FIFO full for the corresponding port; 1 = upstream must not send.
- north_out / south_out / east_out / west_out / local_out, output, BUS_WIDTH, outgoing flit per port.

Behaviour:

Flit format:
- bit[BUS_WIDTH-1] = valid.
- dest_y = flit[CW-1:0].
- dest_x = flit[2*CW-1:CW].
- Remaining bits are payload, passed unmodified.
- A flit with valid = 0 is idle and is ignored.

Reset (rst = 0, asynchronous):
- All *_out = 0.
- All bf_op_* = 0.
- All FIFOs empty.
- All round-robin pointers = north.
- Port index order: north = 0, south = 1, east = 2, west = 3, local = 4.

Input stage:
- On each rising edge, a port with valid = 1 and FIFO not full pushes its flit.
- A valid flit presented while the FIFO is full is dropped. Upstream is responsible for honouring bf_op.
- A push is refused when the FIFO is full, even if a pop occurs in the same cycle.
- bf_op_<port> is registered and equals 1 exactly when that FIFO holds DEPTH entries.
- Simultaneous push and pop on a non-full FIFO keeps the count unchanged.

Routing (combinational on each FIFO head):
- dest_x > LOC_X -> east.
- dest_x < LOC_X -> west.
- Otherwise dest_y > LOC_Y -> north.
- dest_y < LOC_Y -> south.
- Otherwise -> local.
- U-turns are permitted; no special case is made.

Switch allocation (per output, each cycle):
- Requesters are the non-empty FIFOs whose head routes to that output.
- If bf_inp_<output> = 1, no grant is issued.
- Otherwise exactly one requester is granted: the first requester at or after the round-robin pointer in index order, wrapping 4 -> 0.
- After a grant, the pointer moves to the granted index + 1 (mod 5).
- Different outputs may be granted to different inputs in the same cycle.
- An input can be granted by at most one output, because it has one head.

Output stage:
- The granted head is popped, and the flit is registered onto <output>_out at the same edge.
- An output with no grant drives all zeros (valid = 0) that cycle.
- Each flit appears on its output for exactly one cycle.

Latency:
- Flit present at edge N (empty FIFO, no contention, bf_inp low) -> pushed at N, granted combinationally after N, visible on output after edge N+1.
- Minimum latency is 2 edges.

Ordering:
- Flits from one input to one output stay in FIFO order.

Reset mid-operation:
- Buffered flits are discarded immediately, and outputs go to 0 asynchronously.

Test Plan:
1. Params LOC_X = 1, LOC_Y = 2, NOC_SIZE = 4. After reset, local_in = 0x8000000E (x = 3, y = 2) for 1 cycle -> east_out = 0x8000000E exactly 2 edges later, all other outputs 0; 0x80000006 -> local_out; 0x80000004 -> south_out; 0x80000003 (x = 0) -> west_out; 0x8000000B (x = 2) -> east_out; 0x80000007 (y = 3) -> north_out.
2. north_in, south_in, west_in and local_in all = 0x8000000E in the same cycle -> east_out carries north, south, west, local in successive cycles (round-robin); next contention round starts after local.
3. bf_inp_east = 1, stream 0x8000000E on west_in every cycle -> east_out stays 0; bf_op_west rises after DEPTH = 4 pushes; release bf_inp_east -> the 4 flits emerge in order on consecutive cycles, and bf_op_west falls one edge after the first pop.
4. Idle inputs (bit 31 = 0, other bits random) on all ports for 20 cycles -> all outputs 0, all bf_op 0.
5. Assert rst = 0 asynchronously while FIFOs hold flits -> outputs and bf_op go 0 immediately; after release, no stale flits emerge.
6. Random valid traffic, with each input driven only when its bf_op = 0, for 1000 cycles -> every flit emerges exactly once on its XY-correct port, per-input/output order preserved.
